// File: rtl/spawnin_queue_arbiter.sv
// Round-robin, non-preemptive two-master arbiter for the SpawnInQueue BRAM port.
// A master owns the port for as long as it holds req; a watchdog flags long holds.
module spawnin_queue_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_HOLD   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  output logic                  m0_gnt,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [7:0]            m0_we,
  input  logic [63:0]           m0_din,
  output logic [63:0]           m0_dout,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  output logic                  m1_gnt,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [7:0]            m1_we,
  input  logic [63:0]           m1_din,
  output logic [63:0]           m1_dout,
  output logic                  m1_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic [7:0]            mem_we,
  output logic [63:0]           mem_din,
  input  logic [63:0]           mem_dout,
  output logic                  mem_clk,
  output logic                  mem_rst,
  output logic                  hold_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_owner;
  logic        last_nxt;
  logic [15:0] hold_cnt;
  logic [15:0] hold_inc;
  logic        sel0;
  logic        sel1;
  logic        waiting;
  logic        moving;
  logic        hit;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req)
          state_nxt = last_owner ? OWN0 : OWN1;
        else if (m0_req)
          state_nxt = OWN0;
        else if (m1_req)
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_req) begin
          last_nxt  = 1'b0;
          state_nxt = m1_req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          last_nxt  = 1'b1;
          state_nxt = m0_req ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
    end
  end

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);

  // Owner signals reach the BRAM only while its req is still up.
  assign sel0 = m0_gnt && m0_req;
  assign sel1 = m1_gnt && m1_req;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (1'b1)
      sel0: begin
        mem_en   = 1'b1;
        mem_we   = m0_we;
        mem_addr = m0_addr;
        mem_din  = m0_din;
      end
      sel1: begin
        mem_en   = 1'b1;
        mem_we   = m1_we;
        mem_addr = m1_addr;
        mem_din  = m1_din;
      end
      default: ;
    endcase
  end

  assign m0_dout = mem_dout;
  assign m1_dout = mem_dout;
  assign mem_clk = clk;
  assign mem_rst = 1'b0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= sel0;
      m1_rvalid <= sel1;
    end
  end

  assign waiting  = (m0_gnt && m1_req) || (m1_gnt && m0_req);
  assign moving   = (state_nxt != state);
  assign hold_inc = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
  assign hit      = (MAX_HOLD != 0) &&
                    (int'({16'd0, hold_inc}) >= MAX_HOLD);

  // Flag rises on the edge where the count reaches MAX_HOLD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else if (moving) begin
      hold_cnt <= '0;
    end else if (waiting) begin
      hold_cnt <= hold_inc;
      if (hit)
        hold_timeout <= 1'b1;
    end
  end

endmodule
